// File: rtl/rtos_cmd_issuer_if.sv
// Command bundle between the CPU/syscall side and rtos_cmd_issuer, plus the
// strobe/data lines the issuer drives toward the task list manager.
interface rtos_cmd_issuer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic [2:0]    cmd_op_in;
  logic [7:0]    cmd_id_in;
  logic [5:0]    cmd_prio_in;
  logic [31:0]   cmd_arg_in;
  logic [31:0]   tickval_in;
  logic          createTask_out;
  logic          suspendTask_out;
  logic          resumeTask_out;
  logic          delayTask_out;
  logic [7:0]    idTask_out;
  logic [5:0]    priority_out;
  logic [31:0]   addrTCB_out;
  logic [31:0]   valueDelay_out;
  logic          cmd_done_out;
  logic          cmd_err_out;
  logic [LW-1:0] fifo_level_out;

  modport master (
    output cmd_valid_in, cmd_op_in, cmd_id_in, cmd_prio_in, cmd_arg_in, tickval_in,
    input  cmd_ready_out, createTask_out, suspendTask_out, resumeTask_out, delayTask_out,
           idTask_out, priority_out, addrTCB_out, valueDelay_out, cmd_done_out,
           cmd_err_out, fifo_level_out
  );

  modport slave (
    input  cmd_valid_in, cmd_op_in, cmd_id_in, cmd_prio_in, cmd_arg_in, tickval_in,
    output cmd_ready_out, createTask_out, suspendTask_out, resumeTask_out, delayTask_out,
           idTask_out, priority_out, addrTCB_out, valueDelay_out, cmd_done_out,
           cmd_err_out, fifo_level_out
  );
endinterface

// File: rtl/rtos_cmd_issuer.sv
// Buffers task commands and issues them to the list manager as one-cycle strobes
// with registered data, converting relative delays to absolute wake ticks.
module rtos_cmd_issuer #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_TASKS  = 64
) (
  input  logic             aclk,
  input  logic             areset,
  rtos_cmd_issuer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] OP_CREATE  = 3'd1;
  localparam logic [2:0] OP_SUSPEND = 3'd2;
  localparam logic [2:0] OP_RESUME  = 3'd3;
  localparam logic [2:0] OP_DELAY   = 3'd4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_REJECT = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  id;
    logic [5:0]  prio;
    logic [31:0] arg;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        work;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [2:0]    state;
  logic [GW-1:0] gap_cnt;
  logic          full;
  logic          empty;
  logic          ready;
  logic          push;
  logic          pop;
  logic          op_ok;
  logic          id_ok;
  logic          create_q;
  logic          suspend_q;
  logic          resume_q;
  logic          delay_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    id_q;
  logic [5:0]    prio_q;
  logic [31:0]   addr_q;
  logic [31:0]   wake_q;

  // Ready is forced low during reset so nothing is accepted while flushing.
  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign ready = !full && !areset;
  assign push  = bus.cmd_valid_in && ready;
  assign pop   = (state == S_IDLE) && !empty;

  assign op_ok = (work.op == OP_CREATE) || (work.op == OP_SUSPEND) ||
                 (work.op == OP_RESUME) || (work.op == OP_DELAY);
  assign id_ok = ({24'd0, work.id} < 32'(MAX_TASKS));

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_op_in, bus.cmd_id_in, bus.cmd_prio_in, bus.cmd_arg_in};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Strobes and err default low each cycle; data registers hold until the next LOAD exit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= S_IDLE;
      work      <= '0;
      gap_cnt   <= '0;
      create_q  <= 1'b0;
      suspend_q <= 1'b0;
      resume_q  <= 1'b0;
      delay_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      id_q      <= '0;
      prio_q    <= '0;
      addr_q    <= '0;
      wake_q    <= '0;
    end else begin
      create_q  <= 1'b0;
      suspend_q <= 1'b0;
      resume_q  <= 1'b0;
      delay_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            work  <= mem[rd_ptr];
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          id_q <= work.id;
          if (!(op_ok && id_ok)) begin
            err_q <= 1'b1;
            state <= S_REJECT;
          end else begin
            done_q <= 1'b1;
            state  <= S_ISSUE;
            case (work.op)
              OP_CREATE: begin
                create_q <= 1'b1;
                prio_q   <= work.prio;
                addr_q   <= work.arg;
              end
              OP_SUSPEND: begin
                suspend_q <= 1'b1;
                prio_q    <= work.prio;
              end
              OP_RESUME: begin
                resume_q <= 1'b1;
                prio_q   <= work.prio;
              end
              OP_DELAY: begin
                delay_q <= 1'b1;
                wake_q  <= bus.tickval_in + work.arg;
              end
              default: ;
            endcase
          end
        end
        S_ISSUE: begin
          if (GAP_CYCLES == 0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= GW'(GAP_CYCLES - 1);
            state   <= S_GAP;
          end
        end
        S_REJECT: state <= S_IDLE;
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_out   = ready;
  assign bus.createTask_out  = create_q;
  assign bus.suspendTask_out = suspend_q;
  assign bus.resumeTask_out  = resume_q;
  assign bus.delayTask_out   = delay_q;
  assign bus.cmd_done_out    = done_q;
  assign bus.cmd_err_out     = err_q;
  assign bus.idTask_out      = id_q;
  assign bus.priority_out    = prio_q;
  assign bus.addrTCB_out     = addr_q;
  assign bus.valueDelay_out  = wake_q;
  assign bus.fifo_level_out  = level;
endmodule

// File: tb/tb_rtos_cmd_issuer.sv
// Self-checking bench for rtos_cmd_issuer: directed vector table, multi-cycle corner
// sequences, and random traffic against a timeline-based reference model.
module tb_rtos_cmd_issuer;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int MAXT  = 64;

  logic aclk   = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  rtos_cmd_issuer_if #(.FIFO_DEPTH(DEPTH)) bus ();
  rtos_cmd_issuer_if #(.FIFO_DEPTH(DEPTH)) bus0 ();

  rtos_cmd_issuer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .MAX_TASKS(MAXT)) dut (
    .aclk(aclk), .areset(areset), .bus(bus)
  );
  rtos_cmd_issuer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(0), .MAX_TASKS(MAXT)) dut0 (
    .aclk(aclk), .areset(areset), .bus(bus0)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Model: each accepted command gets a pop edge and an event edge on a shared timeline.
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  id;
    logic [5:0]  prio;
    logic [31:0] arg;
    int          pop_e;
    int          ev_e;
    bit          ok;
  } pend_t;

  pend_t       pend[$];
  int          strobe_edges[$];
  int          free_e = 0;
  int          m_lvl = 0;
  bit          last_acc = 0;
  logic [7:0]  m_id = '0;
  logic [5:0]  m_prio = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_delay = '0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  id;
    logic [5:0]  prio;
    logic [31:0] arg;
    logic [31:0] tick;
    logic [5:0]  flags;
    logic [7:0]  e_id;
    logic [5:0]  e_prio;
    logic [31:0] e_addr;
    logic [31:0] e_delay;
  } vec_t;

  vec_t vec[9];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] op, input logic [7:0] id,
                                input logic [5:0] prio, input logic [31:0] arg,
                                input logic [31:0] tk);
    bus.cmd_valid_in = v;
    bus.cmd_op_in    = op;
    bus.cmd_id_in    = id;
    bus.cmd_prio_in  = prio;
    bus.cmd_arg_in   = arg;
    bus.tickval_in   = tk;
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, "_ready"}, 32'(bus.cmd_ready_out), 0);
    check_output({tag, "_strobes"}, 32'({bus.createTask_out, bus.suspendTask_out,
                 bus.resumeTask_out, bus.delayTask_out, bus.cmd_done_out, bus.cmd_err_out}), 0);
    check_output({tag, "_id"}, 32'(bus.idTask_out), 0);
    check_output({tag, "_prio"}, 32'(bus.priority_out), 0);
    check_output({tag, "_addr"}, bus.addrTCB_out, 0);
    check_output({tag, "_delay"}, bus.valueDelay_out, 0);
    check_output({tag, "_level"}, 32'(bus.fifo_level_out), 0);
  endtask

  // One clock: model the edge, then compare every output on the following falling edge.
  task automatic tick();
    pend_t       p;
    logic [31:0] tk;
    logic [3:0]  m_strb;
    logic        m_done;
    logic        m_err;
    bit          m_ready;
    int          lvl;
    m_ready = (m_lvl < DEPTH) && !areset;
    @(posedge aclk);
    edge_n++;
    tk = bus.tickval_in;
    last_acc = 0;
    if (areset) begin
      pend.delete();
      free_e  = 0;
      m_id    = '0;
      m_prio  = '0;
      m_addr  = '0;
      m_delay = '0;
    end else if (bus.cmd_valid_in && m_ready) begin
      last_acc = 1;
      p.op    = bus.cmd_op_in;
      p.id    = bus.cmd_id_in;
      p.prio  = bus.cmd_prio_in;
      p.arg   = bus.cmd_arg_in;
      p.ok    = (p.op >= 3'd1) && (p.op <= 3'd4) && (int'(p.id) < MAXT);
      p.pop_e = (edge_n + 1 > free_e) ? edge_n + 1 : free_e;
      p.ev_e  = p.pop_e + 1;
      free_e  = p.pop_e + (p.ok ? 3 + GAP : 3);
      pend.push_back(p);
    end
    m_strb = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (pend.size() > 0 && pend[0].ev_e == edge_n) begin
      p = pend.pop_front();
      m_id = p.id;
      if (p.ok) begin
        m_done = 1'b1;
        case (p.op)
          3'd1: begin m_strb = 4'b1000; m_prio = p.prio; m_addr = p.arg; end
          3'd2: begin m_strb = 4'b0100; m_prio = p.prio; end
          3'd3: begin m_strb = 4'b0010; m_prio = p.prio; end
          default: begin m_strb = 4'b0001; m_delay = tk + p.arg; end
        endcase
      end else begin
        m_err = 1'b1;
      end
    end
    lvl = 0;
    foreach (pend[i]) if (pend[i].pop_e > edge_n) lvl++;
    m_lvl = lvl;
    @(negedge aclk);
    if (bus.createTask_out || bus.suspendTask_out || bus.resumeTask_out || bus.delayTask_out)
      strobe_edges.push_back(edge_n);
    check_output("strobes", 32'({bus.createTask_out, bus.suspendTask_out,
                 bus.resumeTask_out, bus.delayTask_out}), 32'(m_strb));
    check_output("done", 32'(bus.cmd_done_out), 32'(m_done));
    check_output("err", 32'(bus.cmd_err_out), 32'(m_err));
    check_output("idTask", 32'(bus.idTask_out), 32'(m_id));
    check_output("priority", 32'(bus.priority_out), 32'(m_prio));
    check_output("addrTCB", bus.addrTCB_out, m_addr);
    check_output("valueDelay", bus.valueDelay_out, m_delay);
    check_output("level", 32'(bus.fifo_level_out), 32'(m_lvl));
    check_output("ready", 32'(bus.cmd_ready_out), 32'((m_lvl < DEPTH) && !areset));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (pend.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    repeat (GAP + 2) tick();
    n_cmp++;
    if (n >= 300) begin
      n_bad++;
      $display("[TB] FAIL %s_timeout: got %0d pending, expected 0", tag, pend.size());
    end
  endtask

  initial begin
    int sent;
    int waited;
    int a;
    int d;
    bit hit;
    bit saw_full;
    logic [2:0] rop;

    vec[0] = '{3'd1, 8'd0,  6'h0B, 32'hFAFFFFFF, 32'h0,        6'b100010, 8'd0,  6'h0B, 32'hFAFFFFFF, 32'h0};
    vec[1] = '{3'd4, 8'd1,  6'h03, 32'h11,       32'hAA,       6'b000110, 8'd1,  6'h0B, 32'hFAFFFFFF, 32'hBB};
    vec[2] = '{3'd4, 8'd5,  6'h00, 32'h20,       32'hFFFFFFF0, 6'b000110, 8'd5,  6'h0B, 32'hFAFFFFFF, 32'h10};
    vec[3] = '{3'd5, 8'd7,  6'h01, 32'h0,        32'h0,        6'b000001, 8'd7,  6'h0B, 32'hFAFFFFFF, 32'h10};
    vec[4] = '{3'd2, 8'd64, 6'h02, 32'h0,        32'h0,        6'b000001, 8'd64, 6'h0B, 32'hFAFFFFFF, 32'h10};
    vec[5] = '{3'd3, 8'd2,  6'h2A, 32'h0,        32'h0,        6'b001010, 8'd2,  6'h2A, 32'hFAFFFFFF, 32'h10};
    vec[6] = '{3'd2, 8'd63, 6'h15, 32'h0,        32'h0,        6'b010010, 8'd63, 6'h15, 32'hFAFFFFFF, 32'h10};
    vec[7] = '{3'd0, 8'd3,  6'h07, 32'h0,        32'h0,        6'b000001, 8'd3,  6'h15, 32'hFAFFFFFF, 32'h10};
    vec[8] = '{3'd1, 8'd63, 6'h3F, 32'h12345678, 32'h0,        6'b100010, 8'd63, 6'h3F, 32'h12345678, 32'h10};

    apply_stimulus(0, 0, 0, 0, 0, 0);
    bus0.cmd_valid_in = 0; bus0.cmd_op_in = 0; bus0.cmd_id_in = 0;
    bus0.cmd_prio_in = 0;  bus0.cmd_arg_in = 0; bus0.tickval_in = 0;

    #1 areset = 1'b1;
    #2 check_zero("reset");
    tick();
    tick();
    areset = 1'b0;
    tick();

    $display("[TB] directed vector table");
    foreach (vec[i]) begin
      apply_stimulus(1, vec[i].op, vec[i].id, vec[i].prio, vec[i].arg, vec[i].tick);
      tick();
      apply_stimulus(0, 0, 0, 0, 0, vec[i].tick);
      tick();
      tick();
      check_output($sformatf("vec%0d_flags", i), 32'({bus.createTask_out, bus.suspendTask_out,
                   bus.resumeTask_out, bus.delayTask_out, bus.cmd_done_out, bus.cmd_err_out}),
                   32'(vec[i].flags));
      check_output($sformatf("vec%0d_id", i), 32'(bus.idTask_out), 32'(vec[i].e_id));
      check_output($sformatf("vec%0d_prio", i), 32'(bus.priority_out), 32'(vec[i].e_prio));
      check_output($sformatf("vec%0d_addr", i), bus.addrTCB_out, vec[i].e_addr);
      check_output($sformatf("vec%0d_delay", i), bus.valueDelay_out, vec[i].e_delay);
      repeat (GAP + 2) tick();
    end

    $display("[TB] back-to-back fill past FIFO depth");
    strobe_edges.delete();
    sent = 0;
    waited = 0;
    saw_full = 0;
    apply_stimulus(1, 3'd1 + 3'($urandom_range(0, 3)), 8'($urandom_range(0, 63)),
                   6'($urandom), $urandom, $urandom);
    while (sent < 11 && waited < 200) begin
      tick();
      waited++;
      if (bus.fifo_level_out == DEPTH && !bus.cmd_ready_out) saw_full = 1;
      if (last_acc) begin
        sent++;
        apply_stimulus(sent < 11, 3'd1 + 3'($urandom_range(0, 3)), 8'($urandom_range(0, 63)),
                       6'($urandom), $urandom, $urandom);
      end
    end
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("fill_sent", 32'(sent), 11);
    check_output("fill_full_seen", 32'(saw_full), 1);
    drain("fill");
    check_output("fill_strobe_count", 32'(strobe_edges.size()), 11);
    for (int i = 1; i < strobe_edges.size(); i++)
      check_output($sformatf("fill_spacing%0d", i), 32'(strobe_edges[i] - strobe_edges[i-1]), 32'(3 + GAP));

    $display("[TB] reset during gap with entries queued");
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 3'd2, 8'(20 + k), 6'(k), 32'(k), 32'h100);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("gap_level_before_reset", 32'(bus.fifo_level_out), 3);
    #1 areset = 1'b1;
    #1 check_zero("midrun_reset");
    strobe_edges.delete();
    tick();
    areset = 1'b0;
    repeat (12) tick();
    check_output("no_strobes_after_reset", 32'(strobe_edges.size()), 0);
    apply_stimulus(1, 3'd1, 8'd9, 6'd5, 32'hCAFE0000, 32'h0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    tick();
    check_output("lat_t1_create", 32'(bus.createTask_out), 0);
    tick();
    check_output("lat_t2_create", 32'(bus.createTask_out), 1);
    check_output("lat_t2_addr", bus.addrTCB_out, 32'hCAFE0000);
    tick();
    check_output("lat_t3_create", 32'(bus.createTask_out), 0);
    repeat (GAP + 2) tick();

    $display("[TB] zero-gap instance, 4 queued commands");
    a = edge_n + 1;
    for (int k = 0; k < 16; k++) begin
      bus0.cmd_valid_in = (k < 4);
      bus0.cmd_op_in    = 3'd1;
      bus0.cmd_id_in    = 8'(10 + k);
      bus0.cmd_prio_in  = 6'(k);
      bus0.cmd_arg_in   = 32'(k);
      tick();
      d = edge_n - a;
      hit = (d == 2) || (d == 5) || (d == 8) || (d == 11);
      check_output($sformatf("g0_create_d%0d", d), 32'(bus0.createTask_out), 32'(hit));
      check_output($sformatf("g0_done_d%0d", d), 32'(bus0.cmd_done_out), 32'(hit));
      check_output($sformatf("g0_others_d%0d", d), 32'({bus0.suspendTask_out,
                   bus0.resumeTask_out, bus0.delayTask_out, bus0.cmd_err_out}), 0);
      if (hit) check_output($sformatf("g0_id_d%0d", d), 32'(bus0.idTask_out), 32'(10 + (d - 2) / 3));
    end
    bus0.cmd_valid_in = 0;

    $display("[TB] randomized traffic");
    for (int c = 0; c < 500; c++) begin
      rop = ($urandom_range(0, 9) < 8) ? 3'd1 + 3'($urandom_range(0, 3)) : 3'($urandom);
      apply_stimulus($urandom_range(0, 2) == 0, rop,
                     ($urandom_range(0, 7) == 0) ? 8'($urandom_range(60, 90)) : 8'($urandom_range(0, 63)),
                     6'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'hFFFFFF00 + 32'($urandom_range(0, 255)) : $urandom);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, $urandom);
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
